// File: rtl/cdb_arbiter_if.sv
// CDB arbiter bus: per-unit request/result lanes in, granted write-back out.
interface cdb_arbiter_if #(
  parameter int DATA  = 32,
  parameter int UNITS = 6,
  parameter int RD    = 8,
  parameter int EXP   = 4
);
  logic [UNITS-1:0]           wb_req_;
  logic [UNITS-1:0]           wb_ack_;
  logic [UNITS-1:0][RD-1:0]   unit_pre_rd;
  logic                       pre_wb_e_;
  logic [RD-1:0]              pre_wb_rd;
  logic [UNITS-1:0]           unit_wb_e_;
  logic [UNITS-1:0][RD-1:0]   unit_wb_rd;
  logic [UNITS-1:0][DATA-1:0] unit_wb_data;
  logic [UNITS-1:0]           unit_wb_exp_;
  logic [UNITS-1:0][EXP-1:0]  unit_wb_code;
  logic                       wb_e_;
  logic [RD-1:0]              wb_rd;
  logic [DATA-1:0]            wb_data;
  logic                       wb_exp_;
  logic [EXP-1:0]             wb_exp_code;
  logic                       conflict;
  logic                       proto_err;

  // execution-unit side
  modport master (
    output wb_req_, unit_pre_rd, unit_wb_e_, unit_wb_rd, unit_wb_data, unit_wb_exp_, unit_wb_code,
    input  wb_ack_, pre_wb_e_, pre_wb_rd, wb_e_, wb_rd, wb_data, wb_exp_, wb_exp_code,
           conflict, proto_err
  );

  // arbiter side
  modport slave (
    input  wb_req_, unit_pre_rd, unit_wb_e_, unit_wb_rd, unit_wb_data, unit_wb_exp_, unit_wb_code,
    output wb_ack_, pre_wb_e_, pre_wb_rd, wb_e_, wb_rd, wb_data, wb_exp_, wb_exp_code,
           conflict, proto_err
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: stage 0 grants and pre-broadcasts the destination,
// stage 1 (next cycle) muxes the winner's result onto the CDB.

// Per-unit stage-1 lane: gates one unit's result into an OR-able form.
module cdb_arbiter_lane #(
  parameter int DATA = 32,
  parameter int RD   = 8,
  parameter int EXP  = 4
) (
  input  logic            sel,
  input  logic            wb_e_,
  input  logic [RD-1:0]   rd,
  input  logic [DATA-1:0] data,
  input  logic            exp_,
  input  logic [EXP-1:0]  code,
  output logic            vld,
  output logic            miss,
  output logic [RD-1:0]   rd_o,
  output logic [DATA-1:0] data_o,
  output logic            exc,
  output logic [EXP-1:0]  code_o
);
  // active-low flags inverted so lanes can be OR-combined
  assign vld    = sel & ~wb_e_;
  assign miss   = sel & wb_e_;
  assign exc    = sel & ~exp_;
  assign rd_o   = sel ? rd   : '0;
  assign data_o = sel ? data : '0;
  assign code_o = sel ? code : '0;
endmodule

module cdb_arbiter #(
  parameter int DATA  = 32,
  parameter int UNITS = 6,
  parameter int RD    = 8,
  parameter int EXP   = 4
) (
  input  logic          clk,
  input  logic          reset_,
  input  logic          flush_,
  cdb_arbiter_if.slave  bus
);
  localparam int PW = (UNITS > 1) ? $clog2(UNITS) : 1;

  logic [PW-1:0] rr_ptr, grant_q, win, rr_nxt;
  logic          win_vld, valid_q, s1_act, miss_any;

  logic [UNITS-1:0]           lane_sel, lane_vld, lane_miss, lane_exc;
  logic [UNITS-1:0][RD-1:0]   lane_rd;
  logic [UNITS-1:0][DATA-1:0] lane_data;
  logic [UNITS-1:0][EXP-1:0]  lane_code;

  // stage 0: first requester scanning upward from rr_ptr with wrap
  always_comb begin
    int          idx;
    logic [PW-1:0] idx_w;
    win     = '0;
    win_vld = 1'b0;
    idx     = 0;
    idx_w   = '0;
    for (int k = UNITS-1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= UNITS) idx = idx - UNITS;
      idx_w = PW'(idx);
      if (!bus.wb_req_[idx_w]) begin
        win     = idx_w;
        win_vld = 1'b1;
      end
    end
    if (!reset_ || !flush_) win_vld = 1'b0;
  end

  assign rr_nxt = (win == PW'(UNITS-1)) ? '0 : win + 1'b1;

  // stage 0 outputs: same-cycle ack and early destination broadcast
  always_comb begin
    bus.wb_ack_   = '1;
    bus.pre_wb_e_ = 1'b1;
    bus.pre_wb_rd = '0;
    if (win_vld) begin
      bus.wb_ack_[win] = 1'b0;
      bus.pre_wb_e_    = 1'b0;
      bus.pre_wb_rd    = bus.unit_pre_rd[win];
    end
  end

  assign bus.conflict = reset_ && flush_ && ($countones(~bus.wb_req_) > 1);

  // stage 0 -> stage 1 registers; pointer only advances on a grant
  always_ff @(posedge clk) begin
    if (!reset_) begin
      rr_ptr        <= '0;
      grant_q       <= '0;
      valid_q       <= 1'b0;
      bus.proto_err <= 1'b0;
    end else begin
      valid_q <= win_vld;
      if (win_vld) begin
        grant_q <= win;
        rr_ptr  <= rr_nxt;
      end
      if (miss_any) bus.proto_err <= 1'b1;
    end
  end

  // stage 1 is killed by flush in the same cycle
  assign s1_act = valid_q && flush_;

  for (genvar i = 0; i < UNITS; i++) begin : g_lane
    assign lane_sel[i] = s1_act && (grant_q == PW'(i));
    cdb_arbiter_lane #(.DATA(DATA), .RD(RD), .EXP(EXP)) u_lane (
      .sel    (lane_sel[i]),
      .wb_e_  (bus.unit_wb_e_[i]),
      .rd     (bus.unit_wb_rd[i]),
      .data   (bus.unit_wb_data[i]),
      .exp_   (bus.unit_wb_exp_[i]),
      .code   (bus.unit_wb_code[i]),
      .vld    (lane_vld[i]),
      .miss   (lane_miss[i]),
      .rd_o   (lane_rd[i]),
      .data_o (lane_data[i]),
      .exc    (lane_exc[i]),
      .code_o (lane_code[i])
    );
  end

  // stage 1: OR-combine the one-hot lanes onto the CDB
  always_comb begin
    logic [RD-1:0]   rd_acc;
    logic [DATA-1:0] data_acc;
    logic [EXP-1:0]  code_acc;
    rd_acc   = '0;
    data_acc = '0;
    code_acc = '0;
    for (int i = 0; i < UNITS; i++) begin
      rd_acc   = rd_acc   | lane_rd[i];
      data_acc = data_acc | lane_data[i];
      code_acc = code_acc | lane_code[i];
    end
    bus.wb_rd       = rd_acc;
    bus.wb_data     = data_acc;
    bus.wb_exp_code = code_acc;
  end

  assign bus.wb_e_   = ~|lane_vld;
  assign bus.wb_exp_ = ~|lane_exc;
  assign miss_any    = |lane_miss;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomised + directed bench for cdb_arbiter with a queue-based scoreboard.
module tb_cdb_arbiter;
  localparam int U = 6;

  logic clk = 1'b0;
  logic reset_, flush_;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.DATA(32), .UNITS(U), .RD(8), .EXP(4)) bus ();
  cdb_arbiter #(.DATA(32), .UNITS(U), .RD(8), .EXP(4)) dut (
    .clk(clk), .reset_(reset_), .flush_(flush_), .bus(bus)
  );

  typedef struct {
    logic [5:0]  ack;
    logic        pre_e;
    logic [7:0]  pre_rd;
    logic        conf;
    logic        wb_e;
    logic [7:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_exp;
    logic [3:0]  code;
    logic        perr;
  } exp_t;
  exp_t q[$];

  int checks = 0, errors = 0;

  // reference model state
  int rr = 0, prev_g = -1;
  bit perr = 0;

  // stimulus knobs
  bit        rst_d = 1, flush_d = 1, rnd_mode = 0, inject_perr = 0, fix_resp = 0;
  bit  [5:0] req = '0;
  logic [7:0]  prd [U];
  logic        ue [U], uexp [U];
  logic [7:0]  urd [U];
  logic [31:0] udata [U];
  logic [3:0]  ucode [U];
  logic [31:0] fix_data = '0;
  logic [7:0]  fix_rd = '0;
  logic        fix_exp = 1'b1;
  logic [3:0]  fix_code = '0;

  task automatic chk(string nm, logic [31:0] a, logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, a, x);
    end
  endtask

  // one clock of stimulus: drive, predict, push, advance model
  task automatic step();
    exp_t e;
    int win, n;
    for (int u = 0; u < U; u++) begin
      ue[u]    = !(u == prev_g && !inject_perr);
      urd[u]   = 8'($urandom);
      udata[u] = $urandom;
      uexp[u]  = 1'($urandom);
      ucode[u] = 4'($urandom);
      if (u == prev_g && fix_resp) begin
        urd[u] = fix_rd; udata[u] = fix_data; uexp[u] = fix_exp; ucode[u] = fix_code;
      end
      if (rnd_mode && !req[u] && ($urandom % 100) < 35) begin
        req[u] = 1'b1;
        prd[u] = 8'($urandom);
      end
    end
    reset_ = rst_d;
    flush_ = flush_d;
    for (int u = 0; u < U; u++) begin
      bus.wb_req_[u]      = !req[u];
      bus.unit_pre_rd[u]  = prd[u];
      bus.unit_wb_e_[u]   = ue[u];
      bus.unit_wb_rd[u]   = urd[u];
      bus.unit_wb_data[u] = udata[u];
      bus.unit_wb_exp_[u] = uexp[u];
      bus.unit_wb_code[u] = ucode[u];
    end
    win = -1;
    if (rst_d && flush_d)
      for (int k = 0; k < U; k++)
        if (win < 0 && req[(rr + k) % U]) win = (rr + k) % U;
    e.ack = '1;
    if (win >= 0) e.ack[win] = 1'b0;
    e.pre_e  = (win < 0);
    e.pre_rd = (win >= 0) ? prd[win] : 8'h00;
    n = $countones(req);
    e.conf = rst_d && flush_d && (n > 1);
    if (prev_g >= 0 && flush_d) begin
      e.wb_e = ue[prev_g]; e.wb_rd = urd[prev_g]; e.wb_data = udata[prev_g];
      e.wb_exp = uexp[prev_g]; e.code = ucode[prev_g];
    end else begin
      e.wb_e = 1'b1; e.wb_rd = '0; e.wb_data = '0; e.wb_exp = 1'b1; e.code = '0;
    end
    e.perr = perr;
    q.push_back(e);
    if (!rst_d) begin
      rr = 0; prev_g = -1; perr = 0;
    end else begin
      if (prev_g >= 0 && flush_d && ue[prev_g]) perr = 1;
      if (win >= 0) begin
        prev_g = win; rr = (win + 1) % U; req[win] = 1'b0;
      end else prev_g = -1;
    end
    @(posedge clk); #1;
  endtask

  // monitor: one expectation per cycle, compared mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("wb_ack_",     32'(bus.wb_ack_),     32'(e.ack));
        chk("pre_wb_e_",   32'(bus.pre_wb_e_),   32'(e.pre_e));
        chk("pre_wb_rd",   32'(bus.pre_wb_rd),   32'(e.pre_rd));
        chk("conflict",    32'(bus.conflict),    32'(e.conf));
        chk("wb_e_",       32'(bus.wb_e_),       32'(e.wb_e));
        chk("wb_rd",       32'(bus.wb_rd),       32'(e.wb_rd));
        chk("wb_data",     bus.wb_data,          e.wb_data);
        chk("wb_exp_",     32'(bus.wb_exp_),     32'(e.wb_exp));
        chk("wb_exp_code", 32'(bus.wb_exp_code), 32'(e.code));
        chk("proto_err",   32'(bus.proto_err),   32'(e.perr));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    for (int u = 0; u < U; u++) prd[u] = '0;
    reset_ = 1'b0; flush_ = 1'b1;
    bus.wb_req_ = '1; bus.unit_pre_rd = '0; bus.unit_wb_e_ = '1; bus.unit_wb_rd = '0;
    bus.unit_wb_data = '0; bus.unit_wb_exp_ = '1; bus.unit_wb_code = '0;
    repeat (2) @(posedge clk);
    #1;
    // reset state
    rst_d = 0; step(); rst_d = 1;

    // alu alone, fixed payload
    req[0] = 1; prd[0] = 8'h15; step();
    fix_resp = 1; fix_rd = 8'h15; fix_data = 32'h1234; fix_exp = 1; fix_code = 0;
    step(); fix_resp = 0;

    // all units continuously from reset
    rst_d = 0; step(); rst_d = 1;
    for (int c = 0; c < 8; c++) begin
      for (int u = 0; u < U; u++) begin req[u] = 1; prd[u] = 8'(8'h40 + u); end
      step();
    end
    req = '0; step();

    // div granted, flush next cycle while fpu requests
    req[1] = 1; prd[1] = 8'h21; step();
    req[2] = 1; prd[2] = 8'h32; flush_d = 0; step();
    flush_d = 1; step(); step();

    // mem with exception
    req[5] = 1; prd[5] = 8'h5A; step();
    fix_resp = 1; fix_rd = 8'h5A; fix_data = 32'hCAFE0005; fix_exp = 0; fix_code = 4'h5;
    step(); fix_resp = 0;

    // random traffic with occasional flushes
    rnd_mode = 1;
    for (int c = 0; c < 300; c++) begin
      flush_d = (($urandom % 100) >= 8);
      step();
    end
    rnd_mode = 0; flush_d = 1; req = '0; step(); step();

    // csr protocol error, sticky
    req[4] = 1; prd[4] = 8'h44; step();
    inject_perr = 1; step(); inject_perr = 0;
    repeat (10) step();

    // reset right after a grant
    req = '1; step();
    rst_d = 0; req = '1; step(); rst_d = 1;
    req = '1; step();
    req = '0; step();

    // more random traffic after reset
    rnd_mode = 1;
    for (int c = 0; c < 100; c++) begin
      flush_d = (($urandom % 100) >= 10);
      step();
    end
    rnd_mode = 0; flush_d = 1; req = '0; step();

    @(negedge clk); #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
